// File: rtl/blink_rate_decoder_pkg.sv
// rtl/blink_rate_decoder_pkg.sv - shared timer constants, rate/state types and interval helpers
//
// Purpose : timer frequency constants plus the types and constant functions
//           used to turn a clock frequency into blink-interval windows.
// Ports   : none (package).
package blink_rate_decoder_pkg;

    // Timer frequency constants.
    localparam int TIMER_CLK_50MHZ_HZ = 50_000_000;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        RATE_1HZ  = 2'd1,
        RATE_5HZ  = 2'd2,
        RATE_10HZ = 2'd3
    } rate_t;

    typedef enum logic {
        WAIT_EDGE = 1'b0,
        MEASURE   = 1'b1
    } state_t;

    // Nominal toggle interval in clock cycles for a given rate.
    function automatic longint nominal_interval(input longint freq_hz, input rate_t r);
        case (r)
            RATE_1HZ:  return freq_hz;
            RATE_5HZ:  return freq_hz / 64'sd5;
            RATE_10HZ: return freq_hz / 64'sd10;
            default:   return 64'sd0;
        endcase
    endfunction

    // No edge for 1.5 s means the source has stopped.
    function automatic longint timeout_interval(input longint freq_hz);
        return freq_hz * 64'sd3 / 64'sd2;
    endfunction

    // 64-bit arithmetic keeps N*(100+pct) from overflowing at real clock rates.
    function automatic longint window_lo(input longint nominal, input longint pct);
        return nominal * (64'sd100 - pct) / 64'sd100;
    endfunction

    function automatic longint window_hi(input longint nominal, input longint pct);
        return nominal * (64'sd100 + pct) / 64'sd100;
    endfunction

    function automatic logic [2:0] rate_to_led(input rate_t r);
        case (r)
            RATE_1HZ:  return 3'b001;
            RATE_5HZ:  return 3'b010;
            RATE_10HZ: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/blink_rate_decoder_sync_edge_detect.sv
// rtl/blink_rate_decoder_sync_edge_detect.sv - two-flop synchronizer with any-edge pulse
//
// Purpose : brings an asynchronous input into the clock domain and flags
//           every transition with a one-cycle pulse.
// Ports   : clock      - system clock
//           reset_n    - asynchronous active-low reset
//           din        - asynchronous input
//           edge_pulse - high for one cycle per transition of the synchronized input
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic edge_pulse
);

    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection.
    logic [2:0] shift;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift <= 3'b000;
        end else begin
            shift <= {shift[1:0], din};
        end
    end

    assign edge_pulse = shift[2] ^ shift[1];

endmodule

// File: rtl/blink_rate_decoder.sv
// rtl/blink_rate_decoder.sv - classifies LED toggle intervals into 1/5/10 Hz rates
//
// Purpose : measures the interval between blink_in edges, requires
//           CONFIRM_COUNT consecutive matching intervals before reporting a rate,
//           and drops to NONE on an out-of-window interval or a timeout.
// Ports   : clock        - system clock
//           reset_n      - asynchronous active-low reset
//           blink_in     - asynchronous LED signal
//           rate         - decoded rate code
//           rate_changed - one-cycle pulse whenever rate changes
//           led          - one-hot rate display (001=1 Hz, 010=5 Hz, 100=10 Hz)
module blink_rate_decoder
    import blink_rate_decoder_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = TIMER_CLK_50MHZ_HZ,
    parameter int TOLERANCE_PCT = 5,
    parameter int CONFIRM_COUNT = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       blink_in,
    output rate_t      rate,
    output logic       rate_changed,
    output logic [2:0] led
);

    localparam longint FREQ = longint'(CLOCK_FREQ_HZ);
    localparam longint PCT  = longint'(TOLERANCE_PCT);
    localparam longint TO_L = timeout_interval(FREQ);
    localparam int     CW   = $clog2(TO_L + 64'sd1);
    localparam int     MW   = $clog2(CONFIRM_COUNT + 1);

    localparam longint LO1_L  = window_lo(nominal_interval(FREQ, RATE_1HZ), PCT);
    localparam longint HI1_L  = window_hi(nominal_interval(FREQ, RATE_1HZ), PCT);
    localparam longint LO5_L  = window_lo(nominal_interval(FREQ, RATE_5HZ), PCT);
    localparam longint HI5_L  = window_hi(nominal_interval(FREQ, RATE_5HZ), PCT);
    localparam longint LO10_L = window_lo(nominal_interval(FREQ, RATE_10HZ), PCT);
    localparam longint HI10_L = window_hi(nominal_interval(FREQ, RATE_10HZ), PCT);

    // Window bounds are one bit wider than the counter so counter+1 never wraps.
    localparam logic [CW:0]   LO1   = (CW+1)'(LO1_L);
    localparam logic [CW:0]   HI1   = (CW+1)'(HI1_L);
    localparam logic [CW:0]   LO5   = (CW+1)'(LO5_L);
    localparam logic [CW:0]   HI5   = (CW+1)'(HI5_L);
    localparam logic [CW:0]   LO10  = (CW+1)'(LO10_L);
    localparam logic [CW:0]   HI10  = (CW+1)'(HI10_L);
    localparam logic [CW-1:0] TO_C  = CW'(TO_L);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW:0]   ONE_I = (CW+1)'(1);
    localparam logic [MW-1:0] CONF  = MW'(CONFIRM_COUNT);
    localparam logic [MW-1:0] ONE_M = MW'(1);

    // Reset asserts asynchronously but releases two clocks after reset_n rises.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    logic blink_edge;

    sync_edge_detect u_sync_edge_detect (
        .clock      (clock),
        .reset_n    (rst_int_n),
        .din        (blink_in),
        .edge_pulse (blink_edge)
    );

    state_t        state, state_n;
    logic [CW-1:0] counter, counter_n;
    rate_t         cand, cand_n;
    logic [MW-1:0] match_cnt, match_n;
    rate_t         rate_n;
    logic [CW:0]   interval;
    rate_t         cls;

    always_comb begin
        state_n   = state;
        counter_n = counter;
        cand_n    = cand;
        match_n   = match_cnt;
        rate_n    = rate;

        // The edge cycle itself counts, so the measured interval is counter+1.
        interval = {1'b0, counter} + ONE_I;
        if (interval >= LO10 && interval <= HI10) begin
            cls = RATE_10HZ;
        end else if (interval >= LO5 && interval <= HI5) begin
            cls = RATE_5HZ;
        end else if (interval >= LO1 && interval <= HI1) begin
            cls = RATE_1HZ;
        end else begin
            cls = NONE;
        end

        // A confirmed candidate is promoted one clock after it is confirmed;
        // invalid intervals and timeouts below override the promotion.
        if (match_cnt == CONF && cand != NONE && cand != rate) begin
            rate_n = cand;
        end

        case (state)
            WAIT_EDGE: begin
                counter_n = '0;
                if (blink_edge) begin
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (blink_edge) begin
                    counter_n = '0;
                    if (cls == NONE) begin
                        rate_n  = NONE;
                        cand_n  = NONE;
                        match_n = '0;
                    end else if (cls == cand) begin
                        if (match_cnt != CONF) begin
                            match_n = match_cnt + ONE_M;
                        end
                    end else begin
                        cand_n  = cls;
                        match_n = ONE_M;
                    end
                end else if (counter == TO_C) begin
                    rate_n    = NONE;
                    cand_n    = NONE;
                    match_n   = '0;
                    counter_n = '0;
                    state_n   = WAIT_EDGE;
                end else begin
                    counter_n = counter + ONE_C;
                end
            end
            default: begin
                state_n   = WAIT_EDGE;
                counter_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= WAIT_EDGE;
            counter      <= '0;
            cand         <= NONE;
            match_cnt    <= '0;
            rate         <= NONE;
            rate_changed <= 1'b0;
            led          <= 3'b000;
        end else begin
            state        <= state_n;
            counter      <= counter_n;
            cand         <= cand_n;
            match_cnt    <= match_n;
            rate         <= rate_n;
            rate_changed <= (rate_n != rate);
            led          <= rate_to_led(rate_n);
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// tb/tb_blink_rate_decoder.sv - directed self-checking bench for blink_rate_decoder
module tb_blink_rate_decoder;
    import blink_rate_decoder_pkg::*;

    logic       clock;
    logic       reset_n;
    logic       blink_in;
    rate_t      rate;
    logic       rate_changed;
    logic [2:0] led;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int pc     = 0;
    int pc_base;
    int since;

    blink_rate_decoder #(
        .CLOCK_FREQ_HZ (1000),
        .TOLERANCE_PCT (5),
        .CONFIRM_COUNT (2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .blink_in     (blink_in),
        .rate         (rate),
        .rate_changed (rate_changed),
        .led          (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (rate_changed) pc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Toggle blink_in n clock edges after the previous toggle.
    task automatic toggle(input int n);
        repeat (n - since) @(posedge clock);
        #1 blink_in = ~blink_in;
        since = 0;
    endtask

    // Advance k clock edges without toggling and sample 2 time units later.
    task automatic peek(input int k);
        repeat (k) @(posedge clock);
        since += k;
        #2;
    endtask

    task automatic check_out(input string tag, input rate_t r, input logic [2:0] l, input int pulses);
        chk({tag, "_rate"}, rate, r);
        chk({tag, "_led"}, led, l);
        chk({tag, "_pulses"}, pc - pc_base, pulses);
    endtask

    initial begin
        reset_n  = 1'b0;
        blink_in = 1'b0;
        since    = 0;
        pc_base  = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("reset_rate", rate, NONE);
        chk("reset_led", led, 3'b000);
        chk("reset_changed", rate_changed, 1'b0);
        reset_n = 1'b1;

        // 10 Hz lock: three edges, two matching intervals.
        toggle(10);
        toggle(100);
        peek(5);
        chk("lock10_one_interval", rate, NONE);
        toggle(100);
        peek(3);
        chk("lock10_before", rate, NONE);
        peek(1);
        chk("lock10_rate", rate, RATE_10HZ);
        chk("lock10_pulse", rate_changed, 1'b1);
        chk("lock10_led", led, 3'b100);
        peek(2);
        chk("lock10_pulses", pc - pc_base, 1);
        chk("lock10_pulse_gone", rate_changed, 1'b0);

        // 150-cycle interval drops lock, two 100-cycle intervals relock.
        toggle(150);
        peek(5);
        check_out("invalid150", NONE, 3'b000, 2);
        toggle(100);
        peek(5);
        chk("relock_one", rate, NONE);
        toggle(100);
        peek(5);
        check_out("relock", RATE_10HZ, 3'b100, 3);

        // Window boundaries.
        toggle(94);
        peek(5);
        check_out("bound94", NONE, 3'b000, 4);
        toggle(95);
        toggle(105);
        peek(5);
        check_out("bound95_105", RATE_10HZ, 3'b100, 5);
        toggle(106);
        peek(5);
        check_out("bound106", NONE, 3'b000, 6);
        toggle(100);
        toggle(100);
        peek(5);
        check_out("relock2", RATE_10HZ, 3'b100, 7);

        // Reset mid-measurement discards history.
        peek(40);
        reset_n = 1'b0;
        #1;
        chk("midreset_rate", rate, NONE);
        chk("midreset_led", led, 3'b000);
        chk("midreset_changed", rate_changed, 1'b0);
        blink_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        pc_base = pc;
        since = 0;
        toggle(10);
        toggle(100);
        peek(5);
        check_out("postreset_one", NONE, 3'b000, 0);
        toggle(100);
        peek(5);
        check_out("postreset_lock", RATE_10HZ, 3'b100, 1);

        // 5 Hz, then 1 Hz.
        reset_n = 1'b0;
        blink_in = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        pc_base = pc;
        since = 0;
        toggle(10);
        toggle(200);
        toggle(200);
        peek(5);
        check_out("lock5", RATE_5HZ, 3'b010, 1);
        toggle(1000);
        peek(5);
        check_out("switch1_one", RATE_5HZ, 3'b010, 1);
        toggle(1000);
        peek(5);
        check_out("lock1", RATE_1HZ, 3'b001, 2);

        // Timeout: counter reaches 1500 with no edge.
        peek(1498);
        chk("timeout_before", rate, RATE_1HZ);
        peek(1);
        chk("timeout_rate", rate, NONE);
        chk("timeout_led", led, 3'b000);
        chk("timeout_pulse", rate_changed, 1'b1);
        chk("timeout_state", dut.state, WAIT_EDGE);
        peek(3);
        chk("timeout_pulses", pc - pc_base, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
